jump_address: RTL and testbench

Jump-target generator for the MIPS-style fetch path. It forms the pseudo-direct J/JAL target from PC+4 and the 26-bit instruction index, and also resolves JR register targets. It presents the J-format target combinationally and registers a one-cycle-latency resolved redirect (target, link address, taken, misalignment flag) for the PC-select logic. It sits between the decode stage and the PC mux.

---
 rtl/jump_address_if.sv | 32 +++
 rtl/jump_address.sv | 73 +++++++
 tb/tb_jump_address.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/jump_address_if.sv
// Decode-to-PC-mux jump bundle.
// master: decode drives request fields; slave: jump_address drives results.
interface jump_address_if;
  logic [31:0] PCplus4;
  logic [25:0] JumpField;
  logic [31:0] JumpReg;
  logic [1:0]  JumpType;
  logic        in_valid;
  logic [31:0] JumpAddr;
  logic [31:0] target_q;
  logic [31:0] link_q;
  logic        taken_q;
  logic        link_we_q;
  logic        misalign_q;
  logic        out_valid;

  modport master (
    output PCplus4, JumpField, JumpReg,
    output JumpType, in_valid,
    input  JumpAddr, target_q, link_q,
    input  taken_q, link_we_q,
    input  misalign_q, out_valid
  );

  modport slave (
    input  PCplus4, JumpField, JumpReg,
    input  JumpType, in_valid,
    output JumpAddr, target_q, link_q,
    output taken_q, link_we_q,
    output misalign_q, out_valid
  );
endinterface

// File: rtl/jump_address.sv
// Jump-target generator: comb J target, registered redirect.
// Ports: clk, rst (sync high), bus (jump_address_if.slave).
module jump_address (
  input logic         clk,
  input logic         rst,
  jump_address_if.slave bus
);

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_J    = 2'b01;
  localparam logic [1:0] JT_JAL  = 2'b10;
  localparam logic [1:0] JT_JR   = 2'b11;

  logic [31:0] jaddr;
  logic [31:0] target_d;
  logic [31:0] link_d;
  logic        taken_d;
  logic        link_we_d;
  logic        misalign_d;

  // Region bits come straight from PC+4; no adder.
  assign jaddr = {bus.PCplus4[31:28],
                  bus.JumpField, 2'b00};
  assign bus.JumpAddr = jaddr;

  always_comb begin
    target_d   = 32'h0;
    link_d     = 32'h0;
    taken_d    = 1'b0;
    link_we_d  = 1'b0;
    misalign_d = 1'b0;
    if (bus.in_valid) begin
      unique case (bus.JumpType)
        JT_NONE: target_d = bus.PCplus4;
        JT_J: begin
          target_d = jaddr;
          taken_d  = 1'b1;
        end
        JT_JAL: begin
          target_d  = jaddr;
          taken_d   = 1'b1;
          link_d    = bus.PCplus4;
          link_we_d = 1'b1;
        end
        JT_JR: begin
          target_d   = bus.JumpReg;
          taken_d    = 1'b1;
          misalign_d = |bus.JumpReg[1:0];
        end
        default: target_d = bus.PCplus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.target_q   <= 32'h0;
      bus.link_q     <= 32'h0;
      bus.taken_q    <= 1'b0;
      bus.link_we_q  <= 1'b0;
      bus.misalign_q <= 1'b0;
      bus.out_valid  <= 1'b0;
    end else begin
      bus.target_q   <= target_d;
      bus.link_q     <= link_d;
      bus.taken_q    <= taken_d;
      bus.link_we_q  <= link_we_d;
      bus.misalign_q <= misalign_d;
      bus.out_valid  <= bus.in_valid;
    end
  end

endmodule

// File: tb/tb_jump_address.sv
// Directed bench for jump_address.
// Drives bus via interface, checks #1 after posedge.
module tb_jump_address;
  logic clk;
  logic rst;
  int checks;
  int errors;

  jump_address_if bus ();

  jump_address dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] t,
                       input logic [31:0] pc,
                       input logic [25:0] f,
                       input logic [31:0] r);
    bus.in_valid  = v;
    bus.JumpType  = t;
    bus.PCplus4   = pc;
    bus.JumpField = f;
    bus.JumpReg   = r;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b01, 32'h4, 26'd10, 32'h0);
    rst = 1'b1;
    step();
    checks++;
    if (bus.target_q !== 32'h0) begin
      errors++;
      $display("FAIL rst_target got %h exp 0", bus.target_q);
    end
    checks++;
    if ({bus.taken_q, bus.link_we_q, bus.misalign_q,
         bus.out_valid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b exp 0000",
        {bus.taken_q, bus.link_we_q,
         bus.misalign_q, bus.out_valid});
    end
    checks++;
    if (bus.link_q !== 32'h0) begin
      errors++;
      $display("FAIL rst_link got %h exp 0", bus.link_q);
    end
    checks++;
    if (bus.JumpAddr !== 32'h28) begin
      errors++;
      $display("FAIL rst_jaddr got %h exp 28", bus.JumpAddr);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.taken_q, bus.out_valid} !== 2'b11 ||
        bus.target_q !== 32'h28) begin
      errors++;
      $display("FAIL post_rst got t=%b v=%b tgt=%h exp 1 1 28",
        bus.taken_q, bus.out_valid, bus.target_q);
    end
  endtask

  task automatic test_comb();
    logic [31:0] pcs [5];
    logic [25:0] fs [5];
    logic [31:0] exps [5];
    pcs = '{32'h4, 32'h10, 32'h20, 32'hA0000004, 32'hFFFFFFFC};
    fs = '{26'd10, 26'd50, 26'd99, 26'h3FFFFFF, 26'h0};
    exps = '{32'h28, 32'hC8, 32'h18C, 32'hAFFFFFFC, 32'hF0000000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, pcs[i], fs[i], 32'h0);
      #1;
      checks++;
      if (bus.JumpAddr !== exps[i]) begin
        errors++;
        $display("FAIL comb_%0d got %h exp %h",
          i, bus.JumpAddr, exps[i]);
      end
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 2'b10, 32'h00400010, 26'h0100020, 32'h0);
    step();
    checks++;
    if (bus.target_q !== 32'h00400080) begin
      errors++;
      $display("FAIL jal_target got %h exp 00400080", bus.target_q);
    end
    checks++;
    if (bus.link_q !== 32'h00400010) begin
      errors++;
      $display("FAIL jal_link got %h exp 00400010", bus.link_q);
    end
    checks++;
    if ({bus.taken_q, bus.link_we_q, bus.misalign_q,
         bus.out_valid} !== 4'b1101) begin
      errors++;
      $display("FAIL jal_flags got %b exp 1101",
        {bus.taken_q, bus.link_we_q,
         bus.misalign_q, bus.out_valid});
    end
  endtask

  task automatic test_jr();
    drive(1'b1, 2'b11, 32'h00400010, 26'h1, 32'h00401000);
    step();
    checks++;
    if (bus.target_q !== 32'h00401000 || bus.misalign_q !== 1'b0
        || bus.link_q !== 32'h0 || bus.link_we_q !== 1'b0) begin
      errors++;
      $display("FAIL jr_aligned got tgt=%h mis=%b lnk=%h we=%b",
        bus.target_q, bus.misalign_q, bus.link_q, bus.link_we_q);
    end
    drive(1'b1, 2'b11, 32'h00400010, 26'h1, 32'h00401002);
    step();
    checks++;
    if (bus.target_q !== 32'h00401002 ||
        {bus.taken_q, bus.misalign_q} !== 2'b11) begin
      errors++;
      $display("FAIL jr_misalign got tgt=%h t=%b m=%b exp 00401002 1 1",
        bus.target_q, bus.taken_q, bus.misalign_q);
    end
  endtask

  task automatic test_none();
    drive(1'b1, 2'b00, 32'h00400020, 26'h55, 32'h3);
    step();
    checks++;
    if (bus.taken_q !== 1'b0 || bus.target_q !== 32'h00400020 ||
        bus.out_valid !== 1'b1 || bus.misalign_q !== 1'b0) begin
      errors++;
      $display("FAIL none got t=%b tgt=%h v=%b m=%b exp 0 00400020 1 0",
        bus.taken_q, bus.target_q, bus.out_valid, bus.misalign_q);
    end
  endtask

  task automatic test_invalid();
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 2'(t), 32'h00400020, 26'h55, 32'h3);
      step();
      checks++;
      if (bus.target_q !== 32'h0 || bus.link_q !== 32'h0 ||
          {bus.taken_q, bus.link_we_q, bus.misalign_q,
           bus.out_valid} !== 4'b0) begin
        errors++;
        $display("FAIL invalid_%0d got tgt=%h lnk=%h flags=%b exp 0",
          t, bus.target_q, bus.link_q,
          {bus.taken_q, bus.link_we_q,
           bus.misalign_q, bus.out_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b01, 32'h10000000, 26'h4, 32'h0);
    step();
    checks++;
    if (bus.taken_q !== 1'b1 || bus.target_q !== 32'h10000010) begin
      errors++;
      $display("FAIL b2b_0 got t=%b tgt=%h exp 1 10000010",
        bus.taken_q, bus.target_q);
    end
    drive(1'b1, 2'b10, 32'h20000008, 26'h8, 32'h0);
    step();
    checks++;
    if (bus.taken_q !== 1'b1 || bus.target_q !== 32'h20000020 ||
        bus.link_q !== 32'h20000008) begin
      errors++;
      $display("FAIL b2b_1 got t=%b tgt=%h lnk=%h exp 1 20000020 20000008",
        bus.taken_q, bus.target_q, bus.link_q);
    end
    drive(1'b0, 2'b01, 32'h20000008, 26'h8, 32'h0);
    step();
    checks++;
    if (bus.taken_q !== 1'b0 || bus.link_we_q !== 1'b0) begin
      errors++;
      $display("FAIL b2b_2 got t=%b we=%b exp 0 0",
        bus.taken_q, bus.link_we_q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
    test_comb();
    test_reset();
    test_jal();
    test_jr();
    test_none();
    test_invalid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
